// File: rtl/divclk_capture_pkg.sv
// ----------------------------------------------------------------------------
// divclk_capture_pkg
// Shared types and constants for the divided-clock sample capture block.
//   edge_sel_e : capture edge selection (rise / fall / both / off)
//   OVF_MAX    : saturation value of the dropped-sample counter
//   TS_W       : timestamp width (used when DIVCLK_CAPTURE_TS_EN is defined)
// ----------------------------------------------------------------------------
package divclk_capture_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2,
        EDGE_OFF  = 2'd3
    } edge_sel_e;

    localparam logic [15:0] OVF_MAX = 16'hFFFF;
    localparam int unsigned TS_W    = 32;

endpackage

// File: rtl/sync_fifo_fwft.sv
// ----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO. The head entry is presented on
// rd_data whenever rd_valid is high; when empty, rd_data holds the last head.
// No write-to-read bypass: a write into an empty FIFO is visible next cycle.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   wr_en      : push wr_data (caller guarantees space, or a same-cycle pop)
//   wr_data    : entry to push
//   rd_en      : pop head (caller qualifies with rd_valid)
//   rd_data    : head entry / last head when empty
//   rd_valid   : FIFO not empty
//   full       : level == DEPTH
//   level      : occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] w_head;

    assign w_head   = r_mem[r_rd_ptr];
    assign rd_valid = (r_level != '0);
    assign full     = (r_level == FULL_LVL);
    assign level    = r_level;
    // Last presented head is kept so the output is stable while empty.
    assign rd_data  = rd_valid ? w_head : r_hold;

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_hold   <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (rd_valid) begin
                r_hold <= w_head;
            end
            unique case ({wr_en, rd_en})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/divclk_sample_capture.sv
// ----------------------------------------------------------------------------
// divclk_sample_capture
// Captures one ADC sample into a FWFT FIFO on selected edges of the divided
// clock level (already in the clk domain) and streams entries out with
// valid/ready. Samples arriving while the FIFO is full (and not being popped)
// are dropped and counted in a saturating counter.
// Build option: DIVCLK_CAPTURE_TS_EN attaches a 32-bit free-running cycle
// timestamp to each entry and adds the dout_ts port.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   div_clk     : divided clock level
//   edge_sel    : 0 rise, 1 fall, 2 both, 3 off (takes effect immediately)
//   din         : ADC sample, taken in the strobe cycle
//   dout        : head sample (holds last value while empty)
//   dout_valid  : head present
//   dout_ready  : consumer accept
//   level       : FIFO occupancy
//   ovf_count   : dropped-sample count, saturating
//   dout_ts     : head timestamp (DIVCLK_CAPTURE_TS_EN only)
// ----------------------------------------------------------------------------
module divclk_sample_capture
    import divclk_capture_pkg::*;
#(
    parameter int unsigned DW    = 14,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     div_clk,
    input  logic [1:0]               edge_sel,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              ovf_count
`ifdef DIVCLK_CAPTURE_TS_EN
    ,
    output logic [TS_W-1:0]          dout_ts
`endif
);

`ifdef DIVCLK_CAPTURE_TS_EN
    localparam int unsigned EW = DW + TS_W;
`else
    localparam int unsigned EW = DW;
`endif

    logic          r_div_prev;
    logic [15:0]   r_ovf;
    logic          w_rise;
    logic          w_fall;
    logic          w_strobe;
    logic          w_rd;
    logic          w_full;
    logic          w_accept;
    logic [EW-1:0] w_wr_data;
    logic [EW-1:0] w_rd_data;

    always_ff @(posedge clk) begin
        // Loads during reset too, so the first cycle out of reset sees no edge.
        r_div_prev <= div_clk;
    end

    always_comb begin
        w_rise   = div_clk & ~r_div_prev;
        w_fall   = ~div_clk & r_div_prev;
        w_strobe = 1'b0;
        unique case (edge_sel_e'(edge_sel))
            EDGE_RISE: w_strobe = w_rise;
            EDGE_FALL: w_strobe = w_fall;
            EDGE_BOTH: w_strobe = w_rise | w_fall;
            EDGE_OFF:  w_strobe = 1'b0;
            default:   w_strobe = 1'b0;
        endcase
    end

    assign w_rd     = dout_valid & dout_ready;
    // A same-cycle pop frees the slot the write needs when full.
    assign w_accept = w_strobe & (~w_full | w_rd);

`ifdef DIVCLK_CAPTURE_TS_EN
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    assign w_wr_data = {r_ts, din};
    assign dout_ts   = w_rd_data[EW-1:DW];
`else
    assign w_wr_data = din;
`endif

    assign dout = w_rd_data[DW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= '0;
        end else if (w_strobe && !w_accept && (r_ovf != OVF_MAX)) begin
            r_ovf <= r_ovf + 16'd1;
        end
    end

    assign ovf_count = r_ovf;

    sync_fifo_fwft #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (w_accept),
        .wr_data  (w_wr_data),
        .rd_en    (w_rd),
        .rd_data  (w_rd_data),
        .rd_valid (dout_valid),
        .full     (w_full),
        .level    (level)
    );

endmodule

// File: tb/tb_divclk_sample_capture.sv
// ----------------------------------------------------------------------------
// tb_divclk_sample_capture
// Directed bench for divclk_sample_capture (DW=14, DEPTH=16). Inputs change
// 1 time unit after a rising clock edge; outputs are compared 1 time unit
// after the following edge, i.e. they show the state produced by that cycle.
// ----------------------------------------------------------------------------
module tb_divclk_sample_capture;

    localparam int unsigned DW    = 14;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          div_clk;
    logic [1:0]    edge_sel;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [4:0]    level;
    logic [15:0]   ovf_count;
`ifdef DIVCLK_CAPTURE_TS_EN
    logic [31:0]   dout_ts;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    divclk_sample_capture #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .div_clk    (div_clk),
        .edge_sel   (edge_sel),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level),
        .ovf_count  (ovf_count)
`ifdef DIVCLK_CAPTURE_TS_EN
        ,
        .dout_ts    (dout_ts)
`endif
    );

    typedef struct {
        logic          rst;
        logic          div;
        logic [1:0]    sel;
        logic [DW-1:0] din;
        logic          rdy;
        logic          exp_valid;
        logic [DW-1:0] exp_dout;
        logic [4:0]    exp_level;
        logic [15:0]   exp_ovf;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs and advance past the next rising edge.
    task automatic step(input logic r, input logic d, input logic [1:0] s,
                        input logic [DW-1:0] x, input logic rd);
        rst        = r;
        div_clk    = d;
        edge_sel   = s;
        din        = x;
        dout_ready = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; div_clk = 1'b1; edge_sel = 2'd0; din = '0; dout_ready = 1'b0;
        #1;

        // Short mixed-behaviour table: edge selection, FWFT timing, hold, reset.
        vecs[0]  = '{1'b1, 1'b1, 2'd0, 14'h0000, 1'b0, 1'b0, 14'h0000, 5'd0, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 2'd0, 14'h0000, 1'b0, 1'b0, 14'h0000, 5'd0, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 2'd0, 14'h0005, 1'b0, 1'b0, 14'h0000, 5'd0, 16'd0};
        vecs[3]  = '{1'b0, 1'b1, 2'd0, 14'h0011, 1'b0, 1'b1, 14'h0011, 5'd1, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 2'd1, 14'h0022, 1'b0, 1'b1, 14'h0011, 5'd2, 16'd0};
        vecs[5]  = '{1'b0, 1'b0, 2'd2, 14'h0033, 1'b1, 1'b1, 14'h0022, 5'd1, 16'd0};
        vecs[6]  = '{1'b0, 1'b1, 2'd3, 14'h0044, 1'b0, 1'b1, 14'h0022, 5'd1, 16'd0};
        vecs[7]  = '{1'b0, 1'b0, 2'd2, 14'h0055, 1'b1, 1'b1, 14'h0055, 5'd1, 16'd0};
        vecs[8]  = '{1'b0, 1'b0, 2'd2, 14'h0000, 1'b1, 1'b0, 14'h0055, 5'd0, 16'd0};
        vecs[9]  = '{1'b0, 1'b1, 2'd0, 14'h3FFF, 1'b1, 1'b1, 14'h3FFF, 5'd1, 16'd0};
        vecs[10] = '{1'b1, 1'b0, 2'd1, 14'h0066, 1'b0, 1'b0, 14'h0000, 5'd0, 16'd0};
        vecs[11] = '{1'b0, 1'b0, 2'd1, 14'h0000, 1'b0, 1'b0, 14'h0000, 5'd0, 16'd0};

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst, vecs[i].div, vecs[i].sel, vecs[i].din, vecs[i].rdy);
            chk($sformatf("vec%0d valid", i), 32'(dout_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d dout", i), 32'(dout), 32'(vecs[i].exp_dout));
            chk($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].exp_level));
            chk($sformatf("vec%0d ovf", i), 32'(ovf_count), 32'(vecs[i].exp_ovf));
        end

        // Reset with div_clk high, then idle high: no spurious capture.
        step(1'b1, 1'b1, 2'd0, '0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b1, 2'd0, 14'(c), 1'b0);
            chk($sformatf("idle%0d level", c), 32'(level), 32'd0);
        end

        // Period-8 square wave, rising edges only, consumer always ready.
        step(1'b1, 1'b0, 2'd0, '0, 1'b1);
        for (int c = 0; c < 40; c++) begin
            logic ev;
            ev = (c % 8 == 4);
            step(1'b0, (c % 8) >= 4, 2'd0, 14'(c), 1'b1);
            chk($sformatf("rise c%0d valid", c), 32'(dout_valid), 32'(ev));
            if (ev) chk($sformatf("rise c%0d dout", c), 32'(dout), 32'(c));
        end

        // Same wave, both edges: an entry every 4 cycles.
        step(1'b1, 1'b0, 2'd2, '0, 1'b1);
        for (int c = 0; c < 40; c++) begin
            logic ev;
            ev = (c % 4 == 0) && (c > 0);
            step(1'b0, (c % 8) >= 4, 2'd2, 14'(c), 1'b1);
            chk($sformatf("both c%0d valid", c), 32'(dout_valid), 32'(ev));
            if (ev) chk($sformatf("both c%0d dout", c), 32'(dout), 32'(c));
        end

        // Capture disabled.
        step(1'b1, 1'b0, 2'd3, '0, 1'b1);
        for (int c = 0; c < 40; c++) begin
            step(1'b0, (c % 8) >= 4, 2'd3, 14'(c), 1'b1);
            chk($sformatf("off c%0d valid", c), 32'(dout_valid), 32'd0);
        end

        // 20 strobes into a stalled FIFO: 16 kept, 4 dropped, drained in order.
        step(1'b1, 1'b0, 2'd2, '0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, (i % 2 == 0), 2'd2, 14'(100 + i), 1'b0);
        end
        chk("ovfl level", 32'(level), 32'd16);
        chk("ovfl count", 32'(ovf_count), 32'd4);
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("drain%0d valid", j), 32'(dout_valid), 32'd1);
            chk($sformatf("drain%0d dout", j), 32'(dout), 32'(100 + j));
            step(1'b0, 1'b0, 2'd2, '0, 1'b1);
        end
        chk("drained level", 32'(level), 32'd0);
        chk("drained valid", 32'(dout_valid), 32'd0);
        chk("drained ovf", 32'(ovf_count), 32'd4);

        // Full FIFO with strobe and pop in the same cycle; then drain across wrap.
        step(1'b1, 1'b0, 2'd2, '0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, (i % 2 == 0), 2'd2, 14'(100 + i), 1'b0);
        end
        chk("full level", 32'(level), 32'd16);
        step(1'b0, 1'b1, 2'd2, 14'(116), 1'b1);
        chk("fullrw level", 32'(level), 32'd16);
        chk("fullrw ovf", 32'(ovf_count), 32'd0);
        chk("fullrw dout", 32'(dout), 32'd101);
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("wrap%0d dout", j), 32'(dout), 32'(101 + j));
            step(1'b0, 1'b1, 2'd2, '0, 1'b1);
        end
        chk("wrap level", 32'(level), 32'd0);

`ifdef DIVCLK_CAPTURE_TS_EN
        // Rising edges at cycles 5 and 13 after reset release.
        step(1'b1, 1'b0, 2'd0, '0, 1'b0);
        for (int t = 0; t < 16; t++) begin
            step(1'b0, ((t >= 5) && (t < 9)) || (t >= 13), 2'd0, 14'(t), 1'b0);
        end
        chk("ts level", 32'(level), 32'd2);
        chk("ts first", dout_ts, 32'd5);
        chk("ts first dout", 32'(dout), 32'd5);
        step(1'b0, 1'b1, 2'd0, '0, 1'b1);
        chk("ts second", dout_ts, 32'd13);
        chk("ts second dout", 32'(dout), 32'd13);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/divclk_sample_capture.md
# divclk_sample_capture

Downstream consumer of the derived-clock divider: takes the divided clock level (already in the `clk` domain) and, on selected edges of it, captures one ADC sample into a small FIFO. Captured samples leave through a valid/ready stream to the decimated-acquisition path. Dropped samples are counted, and an optional timestamp can be attached to each entry.

## Interface
- `DW`, 14: sample width (signed ADC word).
- `DEPTH`, 16: FIFO depth in entries; power of two, at least 2.
- `clk`  in  1  system clock, 125 MHz; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `div_clk`  in  1  divided clock level from the divider, synchronous to `clk`.
- `edge_sel`  in  2  capture edge: 0 rising, 1 falling, 2 both, 3 capture disabled.
- `din`  in  DW  ADC sample, sampled in the strobe cycle.
- `dout`  out  DW  head-of-FIFO sample.
- `dout_valid`  out  1  head entry present.
- `dout_ready`  in  1  consumer accepts the head entry when high together with `dout_valid`.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `ovf_count`  out  16  dropped-sample counter; saturates at 16'hFFFF.
- `dout_ts`  out  32  head-entry timestamp; present only with `DIVCLK_CAPTURE_TS_EN`.

## Operation
- `div_prev` is a register holding `div_clk` from the previous cycle.
- Edge terms, computed combinationally from `div_clk` and `div_prev`:
  - rise = `div_clk & ~div_prev`
  - fall = `~div_clk & div_prev`
- Strobe by `edge_sel`:
  - 0: rise
  - 1: fall
  - 2: rise or fall
  - 3: never
- A change to `edge_sel` takes effect in the same cycle.
- On a strobe, `din` from that cycle is the write candidate.
- Write acceptance:
  - Accepted if `level < DEPTH`.
  - Also accepted when full if a read (`dout_valid & dout_ready`) happens in the same cycle.
- Otherwise the sample is dropped and `ovf_count` increments by 1, holding at 16'hFFFF.
- Read: when `dout_valid & dout_ready`, the head entry is popped.
- `level` update per cycle:
  - +1 on write only
  - −1 on read only
  - unchanged when both or neither occur
- FIFO is first-word-fall-through: `dout` and `dout_ts` reflect the head whenever `dout_valid` is high.
  - When `dout_valid` is low, `dout` and `dout_ts` hold their last value.
- There is no write-to-read bypass: an entry written into an empty FIFO becomes visible in the following cycle.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Full and empty are derived from `level`.

## Timing
- Reset values:
  - `dout_valid` = 0, `level` = 0, `ovf_count` = 0, `dout` = 0, `dout_ts` = 0
  - pointers = 0, timestamp counter = 0
  - `div_prev` loads the current `div_clk`, so no spurious edge appears in the first cycle after reset.
- Reset mid-operation flushes all entries in one cycle. Any strobe in the reset cycle is ignored.
- Latency:
  - Edge observed on `div_clk` in cycle k → strobe and write in cycle k → `dout_valid` = 1 with that sample in cycle k+1.
  - Pop in cycle k → next entry on `dout` in cycle k+1. Back-to-back pops sustain 1 entry per cycle.
- A `div_clk` toggling every cycle with `edge_sel` = 2 produces one strobe per cycle. This is legal, and the FIFO absorbs it up to DEPTH entries.
- Timestamp counter is 32-bit, increments every cycle, and wraps at 2^32 to 0. The value from the strobe cycle is stored.

## Configuration
- `DIVCLK_CAPTURE_TS_EN` defined:
  - Each FIFO entry is DW+32 bits wide.
  - `dout_ts` is present and carries the cycle count of the entry's strobe.
  - Free-running counter is instantiated.
- `DIVCLK_CAPTURE_TS_EN` undefined:
  - Entries are DW bits wide.
  - `dout_ts` port and timestamp counter are absent.
  - All other behaviour is identical.

## Structure
- Package `divclk_capture_pkg` holds:
  - the `edge_sel` enum: EDGE_RISE = 0, EDGE_FALL = 1, EDGE_BOTH = 2, EDGE_OFF = 3
  - the OVF_MAX constant
  - the TS_W = 32 constant
- Sub-module `sync_fifo_fwft` (parameters WIDTH, DEPTH) provides storage, pointers and `level`.
- The top level contains edge detection, strobe select, overflow counting and the timestamp counter.

## Test plan
- Reset with `div_clk` held high, then release, `edge_sel` = 0 → no write; `level` stays 0 for 10 cycles.
- `div_clk` square wave with period 8 cycles, `edge_sel` = 0, `din` = cycle index, `dout_ready` = 1 → one entry per 8 cycles, each appearing exactly 1 cycle after its rising edge, with the expected `din` values.
- Same stimulus with `edge_sel` = 2 → entries every 4 cycles. With `edge_sel` = 3 → `dout_valid` never asserts.
- `dout_ready` = 0, `edge_sel` = 2, 20 edges, DEPTH = 16 → `level` = 16, `ovf_count` = 4. Draining then yields the first 16 samples in order.
- FIFO full, strobe and pop in the same cycle → write accepted, `level` stays 16, `ovf_count` unchanged.
- With `DIVCLK_CAPTURE_TS_EN`: edges at cycles 5 and 13 after reset release → `dout_ts` = 5 then 13.
